// File: rtl/fir_out_requant.sv
// Requantises wide symmetric-FIR results to audio width (round, shift, clip) and buffers
// them in a small FIFO feeding a valid/ready stream. Optional saturation counter: FIR_OUT_SAT_CNT_EN.
module fir_out_requant #(
  parameter int IN_BITS    = 32,
  parameter int OUT_BITS   = 16,
  parameter int SHIFT      = 11,
  parameter int ROUND      = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_vld,
  input  logic [IN_BITS-1:0]  din,
  output logic [OUT_BITS-1:0] dout,
  output logic                dout_vld,
  input  logic                dout_rdy,
  output logic [LVL_BITS-1:0] fifo_level,
  output logic                sat_flag,
  output logic                overflow,
  output logic [15:0]         sat_cnt
);

  localparam int AW = LVL_BITS - 1;
  localparam logic signed [IN_BITS:0] RND =
    (ROUND != 0) ? ({{IN_BITS{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
  localparam logic signed [IN_BITS:0] MAXV = {{(IN_BITS-OUT_BITS+2){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [IN_BITS:0] MINV = {{(IN_BITS-OUT_BITS+2){1'b1}}, {(OUT_BITS-1){1'b0}}};
  localparam logic [LVL_BITS-1:0] FULL_LVL = LVL_BITS'(FIFO_DEPTH);

  // Stage 1: one extra bit keeps the rounding add from wrapping at max positive.
  logic signed [IN_BITS:0] sum, s1;
  logic                    s1_vld;

  assign sum = $signed({din[IN_BITS-1], din}) + RND;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= din_vld;
      if (din_vld) s1 <= sum >>> SHIFT;
    end
  end

  // Stage 2: clip to output range.
  logic                hi, lo, clip;
  logic [OUT_BITS-1:0] s2;

  always_comb begin
    hi   = s1 > MAXV;
    lo   = s1 < MINV;
    clip = hi | lo;
    s2   = s1[OUT_BITS-1:0];
    if (hi)      s2 = MAXV[OUT_BITS-1:0];
    else if (lo) s2 = MINV[OUT_BITS-1:0];
  end

  // FIFO
  logic [OUT_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                pop, full, push, drop;

  assign dout_vld = fifo_level != '0;
  assign dout     = dout_vld ? mem[rd_ptr] : '0;
  assign pop      = dout_vld & dout_rdy;
  assign full     = fifo_level == FULL_LVL;
  assign push     = s1_vld & (~full | pop);
  assign drop     = s1_vld & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sat_flag   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sat_flag <= s1_vld & clip;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop & ~push) fifo_level <= fifo_level - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef FIR_OUT_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                 sat_cnt <= '0;
    else if (sat_flag && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: queue-based reference model compared every cycle,
// plus hand-computed literal expectations.
module tb_fir_out_requant;
  localparam int IN_BITS = 32, OUT_BITS = 16, SHIFT = 11, DEPTH = 8;

  logic                clk = 1'b0, rst = 1'b1, din_vld = 1'b0, dout_rdy = 1'b0;
  logic [IN_BITS-1:0]  din = '0;
  logic [OUT_BITS-1:0] dout;
  logic                dout_vld, sat_flag, overflow;
  logic [3:0]          fifo_level;
  logic [15:0]         sat_cnt;

  fir_out_requant #(.IN_BITS(32), .OUT_BITS(16), .SHIFT(11), .ROUND(1),
                    .FIFO_DEPTH(8), .LVL_BITS(4)) dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .dout(dout),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .fifo_level(fifo_level),
    .sat_flag(sat_flag), .overflow(overflow), .sat_cnt(sat_cnt));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference arithmetic: floor((x + round) / 2^SHIFT), then clip.
  function automatic longint requant(input logic [31:0] x, input bit rnd, output bit clipped);
    longint v;
    v = longint'($signed(x));
    if (rnd) v = v + (longint'(1) << (SHIFT - 1));
    v = v >>> SHIFT;
    clipped = 1'b0;
    if (v > 32767)  begin v = 32767;  clipped = 1'b1; end
    if (v < -32768) begin v = -32768; clipped = 1'b1; end
    return v;
  endfunction

  // Behavioural model: a sample accepted this cycle joins the queue on the next edge.
  logic [15:0] q[$];
  bit          pend_vld, pend_clip, m_ovf, m_satf, mdl_on;
  logic [15:0] pend_val;
  int          m_satc;

  always @(posedge clk) begin
    bit popd, c;
    longint v;
    mdl_on <= 1'b1;
    if (rst) begin
      q.delete(); pend_vld = 0; m_ovf = 0; m_satf = 0; m_satc = 0;
    end else begin
      popd   = (q.size() > 0) && dout_rdy;
      m_satf = pend_vld && pend_clip;
`ifdef FIR_OUT_SAT_CNT_EN
      if (m_satf && m_satc < 65535) m_satc++;
`endif
      if (pend_vld && q.size() == DEPTH && !popd) m_ovf = 1;
      if (popd) void'(q.pop_front());
      if (pend_vld && !(q.size() == DEPTH)) q.push_back(pend_val);
      pend_vld = din_vld;
      v = requant(din, 1'b1, c);
      pend_val  = 16'(v);
      pend_clip = c;
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("dout_vld", dout_vld, q.size() != 0);
      chk("dout", dout, (q.size() != 0) ? q[0] : 16'h0);
      chk("fifo_level", fifo_level, q.size());
      chk("overflow", overflow, m_ovf);
      chk("sat_flag", sat_flag, m_satf);
      chk("sat_cnt", sat_cnt, m_satc);
    end
  end

  task automatic step(input bit v, input logic [31:0] d, input bit r);
    din_vld = v; din = d; dout_rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    rst = 1'b1; din_vld = 1'b1; din = 32'h7FFF_FFFF; dout_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; din_vld = 1'b0;
  endtask

  initial begin
    bit c;
    // Pin the model arithmetic with hand-computed values.
    chk("mdl_3072", requant(32'h0000_0C00, 1, c), 2);
    chk("mdl_m3072", requant(32'hFFFF_F400, 1, c), -1);
    chk("mdl_3ff", requant(32'h0000_03FF, 1, c), 0);
    chk("mdl_fff_trunc", requant(32'h0000_0FFF, 0, c), 1);
    chk("mdl_maxpos", requant(32'h7FFF_FFFF, 1, c), 32767);
    chk("mdl_maxneg", requant(32'h8000_0000, 1, c), -32768);

    do_rst();
    @(negedge clk);
    chk("rst_vld", dout_vld, 0);
    chk("rst_lvl", fifo_level, 0);

    // Rounding cases
    step(1, 32'h0000_0C00, 1); step(0, 0, 1);
    @(negedge clk); chk("t1_dout", dout, 16'h0002); chk("t1_vld", dout_vld, 1); chk("t1_sat", sat_flag, 0);
    step(1, 32'hFFFF_F400, 1); step(0, 0, 1);
    @(negedge clk); chk("t2_neg", dout, 16'hFFFF);
    step(1, 32'h0000_03FF, 1); step(0, 0, 1);
    @(negedge clk); chk("t2_zero", dout, 16'h0000); chk("t2_zvld", dout_vld, 1);

    // Saturation
    do_rst();
    step(1, 32'h7FFF_FFFF, 1); step(0, 0, 1);
    @(negedge clk); chk("t3_pos", dout, 16'h7FFF); chk("t3_psat", sat_flag, 1);
    step(1, 32'h8000_0000, 1); step(0, 0, 1);
    @(negedge clk); chk("t3_neg", dout, 16'h8000); chk("t3_nsat", sat_flag, 1);
    step(0, 0, 1); step(0, 0, 1);
`ifdef FIR_OUT_SAT_CNT_EN
    chk("t3_cnt", sat_cnt, 2);
`else
    chk("t3_cnt", sat_cnt, 0);
`endif

    // Overflow with 9 strobes into 8 entries
    do_rst();
    for (int k = 1; k <= 9; k++) step(1, 32'(k) << 11, 0);
    step(0, 0, 0); step(0, 0, 0);
    @(negedge clk); chk("t4_lvl", fifo_level, 8); chk("t4_ovf", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); chk("t4_order", dout, k);
      step(0, 0, 1);
    end
    @(negedge clk); chk("t4_empty", fifo_level, 0); chk("t4_evld", dout_vld, 0); chk("t4_sticky", overflow, 1);

    // Write and pop on the same edges while full
    do_rst();
    for (int k = 11; k <= 18; k++) step(1, 32'(k) << 11, 0);
    step(0, 0, 0); step(0, 0, 0);
    @(negedge clk); chk("t5_full", fifo_level, 8); chk("t5_head", dout, 11);
    step(1, 32'(21) << 11, 0);
    step(1, 32'(22) << 11, 1); step(1, 32'(23) << 11, 1); step(1, 32'(24) << 11, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    @(negedge clk); chk("t5_lvl", fifo_level, 8); chk("t5_ovf", overflow, 0); chk("t5_head2", dout, 15);
    for (int i = 0; i < 10; i++) step(0, 0, 1);

    // Reset with data queued and a sample in stage 1
    do_rst();
    for (int k = 1; k <= 5; k++) step(1, 32'(k) << 11, 0);
    step(0, 0, 0); step(0, 0, 0);
    @(negedge clk); chk("t6_lvl5", fifo_level, 5);
    step(1, 32'(99) << 11, 0);
    do_rst();
    @(negedge clk);
    chk("t6_vld", dout_vld, 0); chk("t6_lvl", fifo_level, 0);
    chk("t6_ovf", overflow, 0); chk("t6_cnt", sat_cnt, 0);
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    @(negedge clk); chk("t6_gone", dout_vld, 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
